// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared FSM encoding and grant source constants for sram_arbiter
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - combinational winner selection between fetch and data requesters
// Tie-break favours the requester not last granted; with last_grant tied to inst this is data priority.
module sram_arb_pick
    import sram_arb_pkg::*;
(
    input  logic inst_req,
    input  logic data_req,
    input  logic last_grant,
    output logic grant
);

    always_comb begin
        grant = SRC_INST;
        if (inst_req && data_req) begin
            grant = ~last_grant;
        end else if (data_req) begin
            grant = SRC_DATA;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM-like port between fetch and data requesters
// Define SRAM_ARB_RR_EN for round-robin tie-break; default is fixed data-over-inst priority.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq
);

    state_t state;
    state_t next_state;
    logic   load;
    logic   capture;
    logic   win;
    logic   grant;
    logic   last_grant;

`ifdef SRAM_ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= SRC_INST;
        end else if (load) begin
            last_grant <= win;
        end
    end
`else
    assign last_grant = SRC_INST;
`endif

    sram_arb_pick u_pick (
        .inst_req   (inst_req),
        .data_req   (data_req),
        .last_grant (last_grant),
        .grant      (win)
    );

    always_comb begin
        next_state = state;
        load       = 1'b0;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (inst_req || data_req) begin
                    next_state = S_ADDR;
                    load       = 1'b1;
                end
            end
            S_ADDR: begin
                if (mem_addr_ok) begin
                    if (mem_data_ok) begin
                        next_state = S_RESP;
                        capture    = 1'b1;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (mem_data_ok) begin
                    next_state = S_RESP;
                    capture    = 1'b1;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Fields are latched once at grant so the slave sees them stable for the whole access.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant     <= SRC_INST;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= (next_state == S_ADDR);
            if (load) begin
                grant <= win;
                if (win == SRC_DATA) begin
                    mem_wr    <= data_wr;
                    mem_wstrb <= data_wstrb;
                    mem_addr  <= data_addr;
                    mem_wdata <= data_wdata;
                end else begin
                    mem_wr    <= 1'b0;
                    mem_wstrb <= '0;
                    mem_addr  <= inst_addr;
                    mem_wdata <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_done  <= 1'b0;
            data_done  <= 1'b0;
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            inst_done <= capture && (grant == SRC_INST);
            data_done <= capture && (grant == SRC_DATA);
            if (capture && !mem_wr) begin
                if (grant == SRC_DATA) begin
                    data_rdata <= mem_rdata;
                end else begin
                    inst_rdata <= mem_rdata;
                end
            end
        end
    end

    assign stallreq = resetn && (inst_req || data_req) &&
                      !((grant == SRC_DATA) ? data_done : inst_done);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed self-checking bench for sram_arbiter
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        stallreq;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .inst_done   (inst_done),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_done   (data_done),
        .mem_req     (mem_req),
        .mem_wr      (mem_wr),
        .mem_wstrb   (mem_wstrb),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_addr_ok (mem_addr_ok),
        .mem_data_ok (mem_data_ok),
        .mem_rdata   (mem_rdata),
        .stallreq    (stallreq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called in the IDLE cycle with requests set; returns in the RESP cycle.
    task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] rd,
                         input logic is_data);
        tick();
        chk({tag, "_addr"}, mem_addr, addr);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = rd;
        tick();
        mem_data_ok = 1'b0;
        chk({tag, "_done"}, is_data ? data_done : inst_done, 32'd1);
        chk({tag, "_rdata"}, is_data ? data_rdata : inst_rdata, rd);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_done", {inst_done, data_done}, 0);
        chk("rst_addr", mem_addr, 0);
        resetn = 1'b1;
        tick();

        // single inst read, minimum latency
        inst_req  = 1'b1;
        inst_addr = 32'hBFC00000;
        #1 chk("t1_stall_c0", stallreq, 1);
        tick();
        chk("t1_mem_req_c1", mem_req, 1);
        chk("t1_addr_c1", mem_addr, 32'hBFC00000);
        chk("t1_stall_c1", stallreq, 1);
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        chk("t1_mem_req_c2", mem_req, 0);
        chk("t1_stall_c2", stallreq, 1);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h3C1D0000;
        tick();
        mem_data_ok = 1'b0;
        chk("t1_done_c3", inst_done, 1);
        chk("t1_rdata_c3", inst_rdata, 32'h3C1D0000);
        chk("t1_stall_c3", stallreq, 0);
        inst_req = 1'b0;
        tick();
        chk("t1_done_c4", inst_done, 0);
        chk("t1_mem_req_c4", mem_req, 0);

        // data write with three addr_ok wait states
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h00001000;
        data_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_mem_req", mem_req, 1);
            chk("t2_fields", {mem_wr, mem_wstrb, mem_addr[15:0]}, {11'd0, 1'b1, 4'b0011, 16'h1000});
            chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
        end
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        chk("t2_data_state", mem_req, 0);
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hFFFFFFFF;
        tick();
        mem_data_ok = 1'b0;
        chk("t2_done", data_done, 1);
        chk("t2_rdata_kept", data_rdata, 0);
        data_req = 1'b0;
        data_wr  = 1'b0;
        tick();
        chk("t2_done_clr", data_done, 0);

        // addr_ok and data_ok together skip DATA
        inst_req  = 1'b1;
        inst_addr = 32'h00000100;
        tick();
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h12345678;
        tick();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        chk("t3_done", inst_done, 1);
        chk("t3_rdata", inst_rdata, 32'h12345678);
        inst_req = 1'b0;
        tick();
        chk("t3_done_clr", inst_done, 0);

        // reset while in DATA, then a stray data_ok
        data_req  = 1'b1;
        data_addr = 32'h00002000;
        tick();
        mem_addr_ok = 1'b1;
        tick();
        mem_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        chk("t4_rst_mem_req", mem_req, 0);
        chk("t4_rst_addr", mem_addr, 0);
        chk("t4_rst_stall", stallreq, 0);
        chk("t4_rst_rdata", inst_rdata, 0);
        data_req = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hA5A5A5A5;
        tick();
        mem_data_ok = 1'b0;
        chk("t4_stray_done", {inst_done, data_done}, 0);
        chk("t4_stray_rdata", data_rdata, 0);
        chk("t4_stray_req", mem_req, 0);

        // simultaneous requests from reset-fresh arbitration state
        inst_req  = 1'b1;
        inst_addr = 32'h00000300;
        data_req  = 1'b1;
        data_addr = 32'h00000400;
        serve("t5_first", 32'h00000400, 32'h11111111, 1'b1);
`ifdef SRAM_ARB_RR_EN
        tick();
        serve("t5_second", 32'h00000300, 32'h22222222, 1'b0);
        tick();
        serve("t5_third", 32'h00000400, 32'h33333333, 1'b1);
`else
        data_req = 1'b0;
        tick();
        serve("t5_second", 32'h00000300, 32'h22222222, 1'b0);
`endif
        inst_req = 1'b0;
        data_req = 1'b0;
        tick();
        chk("t5_idle", mem_req, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
